// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute over
// one ALU and one unified memory port, with a wait counter that aborts stalled accesses.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       pcen,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic       regwrite,
   output logic [1:0] regdst,
   output logic [1:0] memtoreg,
   output logic       illegal,
   output logic       mem_err,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWR   = 4'd4;
   localparam logic [3:0] MEMWB   = 4'd5;
   localparam logic [3:0] EXECUTE = 4'd6;
   localparam logic [3:0] ALUWB   = 4'd7;
   localparam logic [3:0] BRANCH  = 4'd8;
   localparam logic [3:0] ADDIEX  = 4'd9;
   localparam logic [3:0] ADDIWB  = 4'd10;
   localparam logic [3:0] JUMP    = 4'd11;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0]       state, next;
   logic [CNT_W-1:0] cnt;
   logic             wait_st, timeout;
   logic             pcwrite, branch;
   logic             mem_req_c, iord_c, irwrite_c, memwrite_c, alusrca_c;
   logic             regwrite_c, illegal_c, mem_err_c;
   logic [1:0]       pcsrc_c, alusrcb_c, regdst_c, memtoreg_c;
   logic [2:0]       alucontrol_c;

   // Memory handshake: mem_req (and memwrite for stores) stays high every cycle of an
   // access; the access completes in the first cycle that mem_ready is seen high.
   assign wait_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
   assign timeout = wait_st && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT));

   always_comb begin
      next         = state;
      mem_req_c    = 1'b0;
      iord_c       = 1'b0;
      irwrite_c    = 1'b0;
      memwrite_c   = 1'b0;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      pcsrc_c      = 2'b00;
      alusrca_c    = 1'b0;
      alusrcb_c    = 2'b00;
      alucontrol_c = 3'b000;
      regwrite_c   = 1'b0;
      regdst_c     = 2'b00;
      memtoreg_c   = 2'b00;
      illegal_c    = 1'b0;
      mem_err_c    = 1'b0;
      case (state)
         FETCH: begin
            mem_req_c    = 1'b1;
            alusrcb_c    = 2'b01;
            alucontrol_c = ALU_ADD;
            if (mem_ready) begin
               irwrite_c = 1'b1;
               pcwrite   = 1'b1;
               next      = DECODE;
            end
         end
         DECODE: begin
            alusrcb_c    = 2'b11;
            alucontrol_c = ALU_ADD;
            case (op)
               OP_LW, OP_SW:  next = MEMADR;
               OP_R:          next = EXECUTE;
               OP_BEQ:        next = BRANCH;
               OP_ADDI:       next = ADDIEX;
               OP_J, OP_JAL:  next = JUMP;
               default: begin
                  illegal_c = 1'b1;
                  next      = FETCH;
               end
            endcase
         end
         MEMADR, ADDIEX: begin
            alusrca_c    = 1'b1;
            alusrcb_c    = 2'b10;
            alucontrol_c = ALU_ADD;
            if (state == ADDIEX) next = ADDIWB;
            else if (op == OP_SW) next = MEMWR;
            else                  next = MEMRD;
         end
         MEMRD: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            if (mem_ready) next = MEMWB;
         end
         MEMWR: begin
            mem_req_c  = 1'b1;
            iord_c     = 1'b1;
            memwrite_c = 1'b1;
            if (mem_ready) next = FETCH;
         end
         MEMWB: begin
            regwrite_c = 1'b1;
            memtoreg_c = 2'b01;
            next       = FETCH;
         end
         EXECUTE: begin
            alusrca_c = 1'b1;
            next      = ALUWB;
            case (funct)
               6'b100000: alucontrol_c = ALU_ADD;
               6'b100010: alucontrol_c = ALU_SUB;
               6'b100100: alucontrol_c = ALU_AND;
               6'b100101: alucontrol_c = ALU_OR;
               6'b101010: alucontrol_c = ALU_SLT;
               default: begin
                  illegal_c = 1'b1;
                  next      = FETCH;
               end
            endcase
         end
         ALUWB: begin
            regwrite_c = 1'b1;
            regdst_c   = 2'b01;
            next       = FETCH;
         end
         BRANCH: begin
            alusrca_c    = 1'b1;
            alucontrol_c = ALU_SUB;
            pcsrc_c      = 2'b01;
            branch       = 1'b1;
            next         = FETCH;
         end
         ADDIWB: begin
            regwrite_c = 1'b1;
            next       = FETCH;
         end
         JUMP: begin
            pcsrc_c = 2'b10;
            pcwrite = 1'b1;
            if (op == OP_JAL) begin
               regwrite_c = 1'b1;
               regdst_c   = 2'b10;
               memtoreg_c = 2'b10;
            end
            next = FETCH;
         end
         default: next = FETCH;
      endcase
      // An abort only happens with mem_ready low, so no completion enables are active here.
      if (timeout) begin
         mem_err_c = 1'b1;
         next      = FETCH;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         state <= next;
         // A FETCH abort stays in FETCH, so the counter also restarts on timeout.
         if ((next != state) || timeout) cnt <= '0;
         else if (wait_st && !mem_ready) cnt <= cnt + 1'b1;
      end
   end

   assign mem_req    = reset_n & mem_req_c;
   assign iord       = reset_n & iord_c;
   assign irwrite    = reset_n & irwrite_c;
   assign memwrite   = reset_n & memwrite_c;
   assign pcen       = reset_n & (pcwrite | (branch & zero));
   assign pcsrc      = reset_n ? pcsrc_c : 2'b00;
   assign alusrca    = reset_n & alusrca_c;
   assign alusrcb    = reset_n ? alusrcb_c : 2'b00;
   assign alucontrol = reset_n ? alucontrol_c : 3'b000;
   assign regwrite   = reset_n & regwrite_c;
   assign regdst     = reset_n ? regdst_c : 2'b00;
   assign memtoreg   = reset_n ? memtoreg_c : 2'b00;
   assign illegal    = reset_n & illegal_c;
   assign mem_err    = reset_n & mem_err_c;
   assign state_dbg  = reset_n ? state : 4'd0;

endmodule
